// File: rtl/rxq_desc.sv
// rxq_desc: receive-frame descriptor FIFO with a wishbone pop/inspect interface.
// Define RXQ_DROPCNT_EN to add a saturating drop counter at register 3.
module rxq_desc #(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [1:0]  wb_adr_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  input  logic [1:0]  wb_sel_i,
  input  logic        wb_stb_i,
  output logic        wb_ack_o,
  input  logic        frm_done_i,
  input  logic [10:0] frm_len_i,
  input  logic [3:0]  frm_err_i,
  input  logic        frm_match_i,
  output logic        rx_rdy_o,
  output logic        rxq_irq_o
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW = DEPTH_LOG2 + 1;
  logic [10:0] len_mem [DEPTH];
  logic [4:0] sts_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nxt;
  logic ovf, acc, wr_en, csr_wr, flush, ovf_clr, pop, full, empty, push_ok, drop;
  logic [15:0] csr, rdata, drop_val;
  always_comb begin
    acc = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    wr_en = acc & wb_we_i & (wb_sel_i == 2'b11);
    csr_wr = wr_en & (wb_adr_i == 2'd0);
    flush = csr_wr & wb_dat_i[14];
    ovf_clr = csr_wr & wb_dat_i[15];
    full = count == CW'(DEPTH);
    empty = count == '0;
    pop = wr_en & (wb_adr_i == 2'd2) & ~empty;
    // a same-cycle pop frees the slot for an incoming frame; flush discards it outright
    push_ok = frm_done_i & (~full | pop) & ~flush;
    drop = frm_done_i & full & ~pop & ~flush;
    count_nxt = flush ? '0 : count + CW'(push_ok) - CW'(pop);
    csr = {ovf, full, empty, 8'b0, 5'(count)};
    rdata = wb_adr_i == 2'd0 ? csr :
            wb_adr_i == 2'd1 ? (empty ? 16'h0 : {5'b0, len_mem[rd_ptr]}) :
            wb_adr_i == 2'd2 ? (empty ? 16'h0 : {11'b0, sts_mem[rd_ptr]}) : drop_val;
  end
  always_ff @(posedge wb_clk_i) begin
    if (push_ok) begin
      len_mem[wr_ptr] <= frm_len_i;
      sts_mem[wr_ptr] <= {frm_match_i, frm_err_i};
    end
  end
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      ovf <= 1'b0;
      rx_rdy_o <= 1'b1;
      rxq_irq_o <= 1'b0;
    end else begin
      wb_ack_o <= acc;
      wb_dat_o <= (acc & ~wb_we_i) ? rdata : '0;
      wr_ptr <= flush ? '0 : wr_ptr + DEPTH_LOG2'(push_ok);
      rd_ptr <= flush ? '0 : rd_ptr + DEPTH_LOG2'(pop);
      count <= count_nxt;
      ovf <= drop | (ovf & ~ovf_clr);
      rx_rdy_o <= count_nxt != CW'(DEPTH);
      rxq_irq_o <= count_nxt != '0;
    end
  end
`ifdef RXQ_DROPCNT_EN
  logic [15:0] drop_cnt;
  assign drop_val = drop_cnt;
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) drop_cnt <= '0;
    else if (wr_en && wb_adr_i == 2'd3) drop_cnt <= 16'(drop);
    else if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
  end
`else
  assign drop_val = '0;
`endif
endmodule

// File: tb/tb_rxq_desc.sv
// tb_rxq_desc: directed self-checking bench for rxq_desc.
module tb_rxq_desc;
  logic        clk = 0, rst = 1;
  logic [1:0]  adr = 0, sel = 2'b11;
  logic [15:0] dat_i = 0, dat_o;
  logic        cyc = 0, we = 0, stb = 0, ack;
  logic        frm_done = 0, match = 0, rx_rdy, irq;
  logic [10:0] len = 0;
  logic [3:0]  err = 0;
  logic [15:0] rd;
  int passes = 0, total = 0;
`ifdef RXQ_DROPCNT_EN
  localparam logic [15:0] DROP1 = 16'd1;
`else
  localparam logic [15:0] DROP1 = 16'd0;
`endif

  rxq_desc dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_dat_o(dat_o),
    .wb_cyc_i(cyc), .wb_we_i(we), .wb_sel_i(sel), .wb_stb_i(stb), .wb_ack_o(ack),
    .frm_done_i(frm_done), .frm_len_i(len), .frm_err_i(err), .frm_match_i(match),
    .rx_rdy_o(rx_rdy), .rxq_irq_o(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // one bus cycle, optionally with a frame completing in the same access cycle
  task automatic bus(input logic f, input logic w, input logic [1:0] a, input logic [15:0] d,
                     input logic [10:0] l, output logic [15:0] r);
    @(negedge clk);
    cyc = 1; stb = 1; we = w; adr = a; dat_i = d;
    frm_done = f; len = l; err = 0; match = 0;
    @(posedge clk); #1;
    r = dat_o;
    chk("ack_high", 16'(ack), 16'd1);
    cyc = 0; stb = 0; we = 0; frm_done = 0;
    @(posedge clk); #1;
    chk("ack_one_cycle", 16'(ack), 16'd0);
  endtask

  task automatic push(input logic [10:0] l, input logic [3:0] e, input logic m);
    @(negedge clk);
    frm_done = 1; len = l; err = e; match = m;
    @(posedge clk); #1;
    frm_done = 0;
  endtask

  task automatic rd_reg(input string tag, input logic [1:0] a, input logic [15:0] exp);
    logic [15:0] v;
    bus(0, 0, a, 16'h0, 11'd0, v);
    chk(tag, v, exp);
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [15:0] d);
    logic [15:0] v;
    bus(0, 1, a, d, 11'd0, v);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 0;
    chk("rst_rdy", 16'(rx_rdy), 16'd1);
    chk("rst_irq", 16'(irq), 16'd0);
    chk("rst_ack", 16'(ack), 16'd0);
    chk("rst_dat", dat_o, 16'h0);
    rd_reg("csr_reset", 2'd0, 16'h2000);
    rd_reg("len_empty", 2'd1, 16'h0);

    push(11'd64, 4'h0, 1'b1);
    chk("irq_one", 16'(irq), 16'd1);
    rd_reg("csr_one", 2'd0, 16'h0001);
    rd_reg("len_one", 2'd1, 16'd64);
    rd_reg("sts_one", 2'd2, 16'h0010);
    wr_reg(2'd2, 16'h0);
    rd_reg("csr_popped", 2'd0, 16'h2000);
    chk("irq_popped", 16'(irq), 16'd0);
    push(11'd2047, 4'hA, 1'b0);
    rd_reg("len_max", 2'd1, 16'h07FF);
    rd_reg("sts_err", 2'd2, 16'h000A);
    wr_reg(2'd2, 16'h0);
    wr_reg(2'd2, 16'h0);
    rd_reg("csr_pop_empty", 2'd0, 16'h2000);

    for (int i = 0; i < 5; i++) push(11'(60 + i), 4'h0, 1'b0);
    rd_reg("csr_ovf", 2'd0, 16'hC004);
    chk("rdy_full", 16'(rx_rdy), 16'd0);
    for (int i = 0; i < 4; i++) begin
      rd_reg("pop_order", 2'd1, 16'(60 + i));
      wr_reg(2'd2, 16'h0);
    end
    chk("rdy_drained", 16'(rx_rdy), 16'd1);
    rd_reg("csr_ovf_kept", 2'd0, 16'hA000);
    wr_reg(2'd0, 16'h8000);
    rd_reg("csr_ovf_clr", 2'd0, 16'h2000);
    rd_reg("dropcnt", 2'd3, DROP1);

    for (int i = 0; i < 4; i++) push(11'(70 + i), 4'h0, 1'b0);
    bus(1, 1, 2'd2, 16'h0, 11'd74, rd);
    rd_reg("csr_pushpop_full", 2'd0, 16'h4004);
    for (int i = 0; i < 4; i++) begin
      rd_reg("pushpop_order", 2'd1, 16'(71 + i));
      wr_reg(2'd2, 16'h0);
    end
    rd_reg("csr_pushpop_empty", 2'd0, 16'h2000);

    for (int i = 0; i < 3; i++) push(11'(80 + i), 4'h0, 1'b0);
    rd_reg("csr_three", 2'd0, 16'h0003);
    bus(1, 1, 2'd0, 16'h4000, 11'd83, rd);
    rd_reg("csr_flush", 2'd0, 16'h2000);
    rd_reg("dropcnt_flush", 2'd3, DROP1);

    for (int i = 0; i < 10; i++) begin
      push(11'(100 + i), 4'h0, 1'b0);
      rd_reg("wrap_csr", 2'd0, 16'h0001);
      rd_reg("wrap_len", 2'd1, 16'(100 + i));
      wr_reg(2'd2, 16'h0);
    end
    rd_reg("csr_end", 2'd0, 16'h2000);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule

// File: doc/rxq_desc.md
Name: rxq_desc

Overview:
- Receive-frame descriptor queue sitting directly downstream of the Ethernet receive channel and upstream of the M4 firmware.
- For each completed frame it captures length, error flags and MAC-compare result into a small FIFO.
- Firmware reads and pops entries through the internal wishbone bus at 24140-24146.
- It drives a ready signal that tells the receiver whether another frame may be accepted.

Parameters:
- DEPTH_LOG2, 2, log2 of FIFO entry count (default 4 entries; legal 1..4).

Ports:
- wb_clk_i  in  1  system clock; all logic on its rising edge
- wb_rst_i  in  1  synchronous reset, active-high
- wb_adr_i  in  2  word register select (internal bus address bits [2:1])
- wb_dat_i  in  16  write data
- wb_dat_o  out  16  read data
- wb_cyc_i  in  1  bus cycle
- wb_we_i  in  1  1 = write
- wb_sel_i  in  2  byte selects; writes act only when wb_sel_i[1:0] = 2'b11
- wb_stb_i  in  1  block select strobe (decoded externally)
- wb_ack_o  out  1  acknowledge
- frm_done_i  in  1  one-cycle pulse: frame complete, already synchronized to wb_clk_i
- frm_len_i  in  11  frame byte count, valid with frm_done_i
- frm_err_i  in  4  error flags {crc, align, rxer, long}, valid with frm_done_i
- frm_match_i  in  1  MAC compare hit, valid with frm_done_i
- rx_rdy_o  out  1  1 = queue not full; receiver may start a new frame
- rxq_irq_o  out  1  level: queue non-empty

Behaviour:
- Reset values: wb_ack_o=0, wb_dat_o=0, rx_rdy_o=1, rxq_irq_o=0. FIFO is empty; overflow flag=0; drop counter=0.
- Entry format, 16 bits for length and 8 bits for status:
  - LEN = {5'b0, frm_len_i}
  - STS = {3'b0, frm_match_i, frm_err_i}
- Push: on a frm_done_i cycle while count < 2^DEPTH_LOG2, write the entry at wr_ptr, then wr_ptr+1 (wraps modulo depth) and count+1.
- Push while full: entry discarded, overflow flag set (sticky), drop counter increments.
- Wishbone access:
  - Access = wb_cyc_i & wb_stb_i & ~wb_ack_o.
  - wb_ack_o asserts the cycle after an access and lasts exactly one cycle.
  - wb_dat_o is registered with ack and returns 0 when not acked.
- Registers by wb_adr_i:
  - 0 CSR read:
    - bit15 overflow flag
    - bit14 full
    - bit13 empty
    - bits[4:0] count
    - others 0
  - 0 CSR write:
    - bit15=1 clears overflow flag
    - bit14=1 flushes the FIFO: pointers and count to 0; drop counter unaffected
  - 1 HEAD_LEN read: LEN of head entry without popping; 0 if empty. Writes ignored.
  - 2 HEAD_STS read: {8'b0, STS} of head, no pop. Write (any data) pops: rd_ptr+1, count-1. Pop when empty is ignored.
  - 3 DROPCNT: optional feature, see below.
- Side effects occur in the access cycle, so the acked read data reflects pre-access state.
- Simultaneous push and pop:
  - Both take effect; count is unchanged.
  - When full, the pop frees the slot in the same cycle, so the push is accepted and overflow is not set.
- Flush coincident with push: flush wins, frame discarded; not counted as overflow or drop.
- Overflow clear coincident with an overflowing push: flag ends set (set dominates).
- Outputs: rx_rdy_o = ~full and rxq_irq_o = ~empty, both registered from next-state count, so they track count with no extra lag.
- Reset asserted mid-transaction: all state returns to reset values on that edge; a pending ack is dropped.

Optional Feature:
- RXQ_DROPCNT_EN defined:
  - Register 3 reads a 16-bit drop counter that saturates at 16'hFFFF.
  - Any write to register 3 clears it; a clear coincident with a drop leaves the counter at 1.
- Undefined:
  - No counter logic.
  - Register 3 reads 0, writes are ignored, and it is still acked.

Test Plan:
- Reset, then read CSR -> 16'h2000 (empty). rx_rdy_o=1, rxq_irq_o=0. Ack exactly one cycle after stb.
- Push len=11'd64, err=0, match=1 -> CSR=16'h0001, HEAD_LEN=64, HEAD_STS=16'h0010, rxq_irq_o=1. Write reg2 -> CSR=16'h2000, rxq_irq_o=0.
- Push 5 frames with lengths 60..64 at default depth:
  - CSR=16'hC004, rx_rdy_o=0.
  - Pops return 60, 61, 62, 63 in order.
  - Write CSR 16'h8000 -> overflow cleared.
  - DROPCNT=1 with RXQ_DROPCNT_EN, 0 without.
- Fill to 4 entries, then same-cycle frm_done_i and pop write -> count stays 4, overflow stays 0, and the new entry appears as the 4th pop.
- 3 entries queued, write CSR 16'h4000 in the same cycle as frm_done_i -> CSR=16'h2000, no overflow, DROPCNT unchanged.
- Pointer wrap: 10 push/pop pairs with lengths 100..109 -> every HEAD_LEN matches the pushed value and count never exceeds 1.
